// File: rtl/mdu_pkg.sv
// mdu_pkg: opcodes, FSM states and op-class helpers for the multiply/divide sequencer
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_MADD  = 4'd3,
        OP_MADDU = 4'd4,
        OP_MSUB  = 4'd5,
        OP_MSUBU = 4'd6,
        OP_DIV   = 4'd7,
        OP_DIVU  = 4'd8
    } mdu_op_t;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} mdu_state_t;

    localparam int DIV_ITERS = 32;

    function automatic logic is_signed(input mdu_op_t op);
        return op inside {OP_MULT, OP_MADD, OP_MSUB, OP_DIV};
    endfunction

    function automatic logic is_div(input mdu_op_t op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

    function automatic logic is_acc(input mdu_op_t op);
        return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: unsigned radix-2 restoring divider, one quotient bit per step
module mdu_div_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quot,
    output logic [31:0] rem
);
    logic [31:0] dvs;
    logic [32:0] sh;
    logic        ge;
    logic [31:0] rem_n;

    assign sh    = {rem, quot[31]};
    assign ge    = sh >= {1'b0, dvs};
    assign rem_n = ge ? 32'(sh - {1'b0, dvs}) : sh[31:0];

    // load operands, then shift in one quotient bit per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvs  <= '0;
            quot <= '0;
            rem  <= '0;
        end else if (load) begin
            dvs  <= divisor;
            quot <= dividend;
            rem  <= '0;
        end else if (step) begin
            quot <= {quot[30:0], ge};
            rem  <= rem_n;
        end
    end
endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: sequenced multiply/divide unit owning HI/LO, stalls EXE while busy
module mdu_seq
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  mdu_op_t     op_i,
    input  logic [31:0] src0_i,
    input  logic [31:0] src1_i,
    input  logic        cancel_i,
    input  logic        hi_we_i,
    input  logic        lo_we_i,
    input  logic [31:0] mt_data_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    mdu_state_t       state, state_d;
    mdu_op_t          op_q;
    logic [31:0]      a_q, b_q, abs0, abs1, quot, rem;
    logic [3:0][31:0] pp;
    logic             sgn, accept, dz, neg_q, dneg_q, dz_q, fin_we;
    logic [4:0]       cnt;
    logic [63:0]      p_abs, p, mul_res, div_res, res;

    assign sgn     = is_signed(op_i);
    assign abs0    = (sgn && src0_i[31]) ? -src0_i : src0_i;
    assign abs1    = (sgn && src1_i[31]) ? -src1_i : src1_i;
    assign accept  = state == S_IDLE && start_i && op_i != OP_NONE && !cancel_i;
    assign dz      = is_div(op_i) && src1_i == '0;
    assign stall_o = accept || state == S_MUL || state == S_DIV;
    assign done_o  = state == S_FIN && !cancel_i;
    assign fin_we  = done_o && !dz_q;
    assign p_abs   = {pp[3], 32'd0} + {16'd0, pp[2], 16'd0} + {16'd0, pp[1], 16'd0} + {32'd0, pp[0]};
    assign p       = neg_q ? -p_abs : p_abs;
    assign mul_res = !is_acc(op_q) ? p : (op_q inside {OP_MSUB, OP_MSUBU}) ? {hi_o, lo_o} - p : {hi_o, lo_o} + p;
    assign div_res = {dneg_q ? -rem : rem, neg_q ? -quot : quot};
    assign res     = is_div(op_q) ? div_res : mul_res;

    mdu_div_core u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept && is_div(op_i) && !dz),
        .step     (state == S_DIV),
        .dividend (abs0),
        .divisor  (abs1),
        .quot     (quot),
        .rem      (rem)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // next state: cancel forces IDLE from anywhere
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  state_d = !accept ? S_IDLE : dz ? S_FIN : is_div(op_i) ? S_DIV : S_MUL;
            S_MUL:   state_d = S_FIN;
            S_DIV:   state_d = cnt == 5'(DIV_ITERS - 1) ? S_FIN : S_DIV;
            default: state_d = S_IDLE;
        endcase
        if (cancel_i) state_d = S_IDLE;
    end

    // operand latches, partial products, iteration counter and HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_NONE;
            a_q    <= '0;
            b_q    <= '0;
            neg_q  <= 1'b0;
            dneg_q <= 1'b0;
            dz_q   <= 1'b0;
            pp     <= '0;
            cnt    <= '0;
            hi_o   <= '0;
            lo_o   <= '0;
        end else begin
            if (accept) begin
                op_q   <= op_i;
                a_q    <= abs0;
                b_q    <= abs1;
                neg_q  <= sgn && (src0_i[31] ^ src1_i[31]);
                dneg_q <= sgn && src0_i[31];
                dz_q   <= dz;
            end
            if (state == S_MUL) begin
                pp[0] <= a_q[15:0] * b_q[15:0];
                pp[1] <= a_q[15:0] * b_q[31:16];
                pp[2] <= a_q[31:16] * b_q[15:0];
                pp[3] <= a_q[31:16] * b_q[31:16];
            end
            cnt <= (state == S_DIV && !cancel_i) ? cnt + 5'd1 : 5'd0;
            if (fin_we) begin
                {hi_o, lo_o} <= res;
            end else if (state != S_FIN) begin
                if (hi_we_i) hi_o <= mt_data_i;
                if (lo_we_i) lo_o <= mt_data_i;
            end
        end
    end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed scoreboard bench for the multiply/divide sequencer
module tb_mdu_seq;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    mdu_op_t     op = OP_NONE;
    logic [31:0] src0 = '0, src1 = '0, mt_data = '0;
    logic        cancel = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic        stall, done;
    logic [31:0] hi, lo;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] m_hilo = '0;
    logic [63:0] sb[$];

    mdu_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .op_i      (op),
        .src0_i    (src0),
        .src1_i    (src1),
        .cancel_i  (cancel),
        .hi_we_i   (hi_we),
        .lo_we_i   (lo_we),
        .mt_data_i (mt_data),
        .stall_o   (stall),
        .done_o    (done),
        .hi_o      (hi),
        .lo_o      (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] acc);
        logic signed [63:0] sa, sb_, sp;
        logic [63:0] up;
        logic signed [31:0] qa, qb;
        sa = $signed({{32{a[31]}}, a});
        sb_ = $signed({{32{b[31]}}, b});
        sp = sa * sb_;
        up = {32'd0, a} * {32'd0, b};
        qa = $signed(a);
        qb = $signed(b);
        case (o)
            OP_MULT:  return sp;
            OP_MULTU: return up;
            OP_MADD:  return acc + sp;
            OP_MADDU: return acc + up;
            OP_MSUB:  return acc - sp;
            OP_MSUBU: return acc - up;
            OP_DIV:   return b == 0 ? acc : {32'(qa % qb), 32'(qa / qb)};
            OP_DIVU:  return b == 0 ? acc : {a % b, a / b};
            default:  return acc;
        endcase
    endfunction

    task automatic run_op(input string tag, input mdu_op_t o, input logic [31:0] a, input logic [31:0] b,
                          input int lat);
        int n;
        logic [63:0] exp;
        @(negedge clk);
        start = 1'b1; op = o; src0 = a; src1 = b;
        sb.push_back(model(o, a, b, m_hilo));
        #1 check({tag, "_stall0"}, 64'(stall), 64'd1);
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            if (n == 1) check({tag, "_stall1"}, 64'(stall), 64'd1);
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_finstall"}, 64'(stall), 64'd0);
        @(negedge clk);
        exp = sb.pop_front();
        check({tag, "_hilo"}, {hi, lo}, exp);
        check({tag, "_doneoff"}, 64'(done), 64'd0);
        m_hilo = exp;
    endtask

    task automatic mt(input logic to_hi, input logic [31:0] d);
        @(negedge clk);
        hi_we = to_hi; lo_we = !to_hi; mt_data = d;
        #1 check("mt_stall", 64'(stall), 64'd0);
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        if (to_hi) m_hilo[63:32] = d;
        else       m_hilo[31:0] = d;
        check("mt_hilo", {hi, lo}, m_hilo);
    endtask

    initial begin
        logic [31:0] ra, rb;
        #12;
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mult_m3x5", OP_MULT, 32'hFFFFFFFD, 32'd5, 2);
        check("mult_m3x5_const", m_hilo, 64'hFFFFFFFF_FFFFFFF1);
        run_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 33);
        check("div_m7_2_const", m_hilo, 64'hFFFFFFFF_FFFFFFFD);
        run_op("divu_7_2", OP_DIVU, 32'd7, 32'd2, 33);
        check("divu_7_2_const", m_hilo, 64'h00000001_00000003);
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 33);
        run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
        run_op("mult_min", OP_MULT, 32'h80000000, 32'h80000000, 2);

        mt(1'b1, 32'h12345678);
        mt(1'b0, 32'h9ABCDEF0);
        run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 1);
        check("divu_by0_const", m_hilo, 64'h12345678_9ABCDEF0);

        mt(1'b1, 32'h0);
        mt(1'b0, 32'hFFFFFFFF);
        run_op("maddu_1", OP_MADDU, 32'd1, 32'd1, 2);
        check("maddu_1_const", m_hilo, 64'h00000001_00000000);
        run_op("msubu_1", OP_MSUBU, 32'd1, 32'd1, 2);
        check("msubu_1_const", m_hilo, 64'h00000000_FFFFFFFF);
        run_op("madd_m2x3", OP_MADD, 32'hFFFFFFFE, 32'd3, 2);
        run_op("msub_m4x5", OP_MSUB, 32'hFFFFFFFC, 32'd5, 2);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom | 32'd1;
            run_op("rnd_mult", OP_MULT, ra, rb, 2);
            run_op("rnd_divu", OP_DIVU, ra, rb >> (i * 8), 33);
        end

        mt(1'b1, 32'hCAFEF00D);
        @(negedge clk);
        start = 1'b1; op = OP_DIV; src0 = 32'd100; src1 = 32'd7;
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        #1 check("cxl_div_done", 64'(done), 64'd0);
        @(negedge clk);
        cancel = 1'b0;
        check("cxl_div_stall", 64'(stall), 64'd0);
        check("cxl_div_hilo", {hi, lo}, m_hilo);
        run_op("after_cxl", OP_DIVU, 32'd1000, 32'd3, 33);

        @(negedge clk);
        start = 1'b1; op = OP_MULT; src0 = 32'd9; src1 = 32'd9;
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        @(negedge clk);
        check("cxl_fin_pre", 64'(done), 64'd1);
        cancel = 1'b1;
        #1 check("cxl_fin_done", 64'(done), 64'd0);
        @(negedge clk);
        cancel = 1'b0;
        check("cxl_fin_hilo", {hi, lo}, m_hilo);

        @(negedge clk);
        start = 1'b1; op = OP_MULT; src0 = 32'd2; src1 = 32'd2; cancel = 1'b1;
        #1 check("cxl_start_stall", 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0; op = OP_NONE; cancel = 1'b0;
        check("cxl_start_idle", {62'd0, stall, done}, 64'd0);

        @(negedge clk);
        start = 1'b1; op = OP_MULT; src0 = 32'd3; src1 = 32'd4;
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        #2 rst_n = 1'b0;
        #1 check("rst_mid_hilo", {hi, lo}, 64'd0);
        check("rst_mid_flags", {62'd0, stall, done}, 64'd0);
        m_hilo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        mt(1'b0, 32'h000000A5);
        check("mtlo_a5", {hi, lo}, 64'h00000000_000000A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mdu_seq.md
# mdu_seq

Multi-cycle multiply/divide sequencer and HI/LO register owner for the EXE stage. Accepts MULT/MULTU/MADD/MADDU/MSUB/MSUBU/DIV/DIVU issues and runs a 2-cycle registered multiply or a 32-iteration divide. Holds the pipeline with a stall while busy and commits the 64-bit result to HI/LO. Replaces the single-cycle combinational multiply path in the ALU with a timing-friendly sequenced unit.

## Interface
- No parameters; widths fixed at 32-bit operands and 64-bit HI/LO.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_i` in 1: issue request from EXE, qualified by `op_i`.
- `op_i` in 4: `mdu_op_t` operation code.
- `src0_i` in 32: rs operand (dividend or multiplicand).
- `src1_i` in 32: rt operand (divisor or multiplier).
- `cancel_i` in 1: flush from exception or ERET; aborts any operation.
- `hi_we_i` in 1: MTHI write enable.
- `lo_we_i` in 1: MTLO write enable.
- `mt_data_i` in 32: MTHI/MTLO data.
- `stall_o` out 1: hold EXE and earlier stages.
- `done_o` out 1: result commits at the end of this cycle.
- `hi_o` out 32: registered HI.
- `lo_o` out 32: registered LO.

## Operation
- States: IDLE, MUL, DIV, FIN.
- **Accept:** an op is accepted when state is IDLE, `start_i`=1, `op_i`≠NONE, and `cancel_i`=0.
  - Latch op, operands, and sign flags.
  - Signed ops take two's-complement absolute values; unsigned ops pass operands through.
- **MUL:**
  - Register four 16x16 partial products.
  - Next state is FIN.
- **FIN (multiply):** sum the partial products into a 64-bit product `p`, restore the sign (negate if the operand signs differ, signed ops only), then combine with `{hi,lo}`:
  - MULT/MULTU: `p`.
  - MADD/MADDU: `{hi,lo}+p`.
  - MSUB/MSUBU: `{hi,lo}-p`.
  - Arithmetic is mod 2^64.
- **DIV:**
  - Runs `mdu_div_core` as a radix-2 restoring divider, one quotient bit per cycle.
  - A 5-bit counter runs 0..31; when the counter reaches 31, next state is FIN.
- **FIN (divide):**
  - LO = quotient, negated if the operand signs differ (DIV only).
  - HI = remainder, taking the sign of the dividend (DIV only).
- **Divide by zero** (`src1_i`=0 on DIV or DIVU):
  - Go IDLE→FIN directly.
  - No HI/LO write; `done_o` is still asserted.
- **Commit:**
  - FIN writes HI/LO at the closing edge; next state is IDLE.
  - `done_o`=1 exactly in FIN.
- **Cancel:**
  - Any state goes to IDLE at the next edge.
  - No HI/LO write, even in FIN; `done_o` is forced 0.
  - Cancel overrides start.
- **MTHI/MTLO:**
  - Writes are applied in any state except FIN.
  - In FIN, the FIN commit wins and the MT write is dropped; the decoder guarantees this case does not occur.
  - `hi_we_i` and `lo_we_i` are independent.
- Back-to-back issue: a new start is accepted only in IDLE. The cycle after FIN is IDLE, so a dependent MADD sees the committed HI/LO.

## Timing
- Reset: state=IDLE, `hi_o`=`lo_o`=0, `stall_o`=0, `done_o`=0, counter=0, operand latches=0.
- **`stall_o`** (combinational) = (IDLE & `start_i` & op≠NONE & ~`cancel_i`) | MUL | DIV.
  - It is 0 in FIN, so EXE advances at the same edge that commits HI/LO.
- **Multiply latency:** accept at edge E0, MUL in cycle 1, FIN in cycle 2, HI/LO visible after E2. Stall covers cycles 0–1.
- **Divide latency:** accept at E0, DIV for 32 cycles, FIN in cycle 33, HI/LO visible after E33.
- **Divide by zero:** FIN in cycle 1; no write.
- `hi_o`/`lo_o` are registered, with no bypass of in-flight results.
- `rst_n` asserted mid-operation aborts immediately and asynchronously to the reset values.

## Structure
- Package `mdu_pkg` holds:
  - `mdu_op_t` (4 bits): NONE=0, MULT=1, MULTU=2, MADD=3, MADDU=4, MSUB=5, MSUBU=6, DIV=7, DIVU=8.
  - `mdu_state_t`.
  - Constant `DIV_ITERS`=32.
  - Helper predicates `is_signed`, `is_div`, `is_acc`.
- Sub-module `mdu_div_core`:
  - Owns the partial remainder, quotient shift register, and iteration step.
  - Controlled by `load` and `step` from the parent FSM.
  - Sign handling stays in `mdu_seq`.

## Test plan
- MULT -3 × 5: stall for 2 cycles, then HI=FFFFFFFF, LO=FFFFFFF1; `done_o` high in cycle 2 only.
- DIV -7 / 2: stall for 33 cycles, `done_o` in cycle 33, then LO=FFFFFFFD, HI=FFFFFFFF. Also DIVU 7/2 gives LO=3, HI=1.
- DIVU with divisor 0 and HI/LO preset to 12345678/9ABCDEF0: `done_o` in cycle 1, HI/LO unchanged.
- Preset HI=0, LO=FFFFFFFF; MADDU 1 × 1 gives HI=1, LO=0. Then MSUBU 1 × 1 gives HI=0, LO=FFFFFFFF.
- Cancel during DIV iteration 10: IDLE next cycle, `stall_o`=0, HI/LO unchanged. Cancel during FIN: no commit.
- `rst_n` low mid-MUL: outputs go to 0 immediately. After release, MTLO 0xA5 gives LO=000000A5 with no stall.
